// File: rtl/sram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sram_arb_pkg
// Purpose : Shared types and default constants for the two-port SRAM arbiter.
//           owner_t records which requester owns the read in flight.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package sram_arb_pkg;

  localparam int C_ADDR_WIDTH   = 8;
  localparam int C_DATA_WIDTH   = 8;
  localparam int C_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_t;

endpackage
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : sram_arbiter
// Purpose : Front end for a single-port synchronous SRAM. Arbitrates between
//           a read-only fetch port (A) and a read/write data port (B). B has
//           fixed priority; a starvation counter hands priority to A after
//           STARVE_LIMIT consecutive denied cycles. Read data is returned to
//           the owning port one cycle after grant.
// Ports   : clk, rst_n               clock, async active-low reset
//           a_req/a_addr             port A read request
//           a_gnt/a_rvalid/a_rdata   port A grant and read return
//           b_req/b_we/b_addr/b_wdata port B request
//           b_gnt/b_rvalid/b_rdata   port B grant and read return
//           mem_addr/mem_we/mem_wdata/mem_rdata  SRAM side
// Rev     : 1.0  initial release
// ============================================================================
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = C_ADDR_WIDTH,
  parameter int DATA_WIDTH   = C_DATA_WIDTH,
  parameter int STARVE_LIMIT = C_STARVE_LIMIT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int                   C_CNT_WIDTH = $clog2(STARVE_LIMIT + 1);
  localparam logic [C_CNT_WIDTH-1:0] C_LIMIT   = C_CNT_WIDTH'(STARVE_LIMIT);

  owner_t                 r_owner;
  owner_t                 w_owner_nxt;
  logic [C_CNT_WIDTH-1:0] r_starve_cnt;
  logic [C_CNT_WIDTH-1:0] w_starve_nxt;
  logic                   w_prio_a;

  // --------------------------------------------------------------------------
  // Arbitration: B wins contention unless A has been starved to the limit.
  // --------------------------------------------------------------------------
  assign w_prio_a = (r_starve_cnt == C_LIMIT);
  assign a_gnt    = a_req & (~b_req | w_prio_a);
  assign b_gnt    = b_req & ~(a_req & w_prio_a);

  // --------------------------------------------------------------------------
  // SRAM drive. With no grant the address still follows a requester so the
  // SRAM sees a defined address; mem_we is gated by the grant.
  // --------------------------------------------------------------------------
  assign mem_addr  = a_gnt ? a_addr : (b_req ? b_addr : a_addr);
  assign mem_we    = b_gnt & b_we;
  assign mem_wdata = b_wdata;

  // --------------------------------------------------------------------------
  // Next-state logic for read ownership and the starvation counter.
  // --------------------------------------------------------------------------
  always_comb begin
    w_owner_nxt = OWN_NONE;
    if (a_gnt) begin
      w_owner_nxt = OWN_A;
    end else if (b_gnt & ~b_we) begin
      w_owner_nxt = OWN_B;
    end
  end

  always_comb begin
    w_starve_nxt = r_starve_cnt;
    if (a_gnt | ~a_req) begin
      w_starve_nxt = '0;
    end else if (r_starve_cnt != C_LIMIT) begin
      w_starve_nxt = r_starve_cnt + C_CNT_WIDTH'(1);
    end
  end

  // --------------------------------------------------------------------------
  // State registers. An async reset drops any read in flight.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner      <= OWN_NONE;
      r_starve_cnt <= '0;
    end else begin
      r_owner      <= w_owner_nxt;
      r_starve_cnt <= w_starve_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Read return: SRAM output is shared; rvalid steers it to the owner.
  // --------------------------------------------------------------------------
  assign a_rvalid = (r_owner == OWN_A);
  assign b_rvalid = (r_owner == OWN_B);
  assign a_rdata  = mem_rdata;
  assign b_rdata  = mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_sram_arbiter
// Purpose : Self-checking bench for sram_arbiter with a behavioural SRAM and
//           a reference model of grants, ownership and memory contents.
// Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sram_arbiter;

  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_req = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic          a_gnt, a_rvalid;
  logic [DW-1:0] a_rdata;
  logic          b_req = 1'b0;
  logic          b_we = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_wdata = '0;
  logic          b_gnt, b_rvalid;
  logic [DW-1:0] b_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_addr(a_addr), .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural single-port SRAM: registered read, output held on writes.
  logic [DW-1:0] sram_mem [0:255];
  logic [DW-1:0] sram_q;
  always @(posedge clk) begin
    if (mem_we) sram_mem[mem_addr] <= mem_wdata;
    else        sram_q <= sram_mem[mem_addr];
  end
  assign mem_rdata = sram_q;

  // Reference model state.
  logic [DW-1:0] ref_mem [0:255];
  int            denied = 0;
  logic          exp_av = 1'b0, exp_bv = 1'b0;
  logic [DW-1:0] exp_rd = '0;
  logic          e_agnt, e_bgnt, e_we;
  logic [AW-1:0] e_addr;

  function automatic void ref_eval();
    logic prio;
    prio = (denied >= LIM);
    if (a_req && b_req) begin
      e_agnt = prio;
      e_bgnt = !prio;
    end else begin
      e_agnt = a_req;
      e_bgnt = b_req;
    end
    e_addr = e_agnt ? a_addr : (b_req ? b_addr : a_addr);
    e_we   = e_bgnt && b_we;
  endfunction

  function automatic void ref_commit();
    exp_av = e_agnt;
    exp_bv = e_bgnt && !b_we;
    if (exp_av || exp_bv) exp_rd = ref_mem[e_addr];
    if (e_we) ref_mem[b_addr] = b_wdata;
    denied = (a_req && !e_agnt) ? denied + 1 : 0;
  endfunction

  function automatic void ref_reset();
    denied = 0;
    exp_av = 1'b0;
    exp_bv = 1'b0;
  endfunction

  task automatic drive(input logic ar, input logic [AW-1:0] aa, input logic br,
                       input logic bw, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
    a_req = ar; a_addr = aa; b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    #2;
    ref_eval();
  endtask

  task automatic tick();
    ref_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    ref_reset();
    checks++; if (a_rvalid !== 1'b0) begin failures++; $display("FAIL reset_a_rvalid got=%b want=0", a_rvalid); end
    checks++; if (b_rvalid !== 1'b0) begin failures++; $display("FAIL reset_b_rvalid got=%b want=0", b_rvalid); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%b want=0", mem_we); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      tick();
      checks++; if ({a_rvalid, b_rvalid} !== 2'b00) begin failures++; $display("FAIL idle_rvalid got=%b want=00", {a_rvalid, b_rvalid}); end
    end
  endtask

  task automatic test_b_write_read();
    drive(0, 0, 1, 1, 8'h10, 8'h5A);
    checks++; if ({a_gnt, b_gnt, mem_we} !== 3'b011) begin failures++; $display("FAIL bwr_grant got=%b want=011", {a_gnt, b_gnt, mem_we}); end
    checks++; if (mem_addr !== 8'h10) begin failures++; $display("FAIL bwr_addr got=%h want=10", mem_addr); end
    tick();
    drive(0, 0, 1, 0, 8'h10, 8'h00);
    checks++; if ({b_gnt, mem_we} !== 2'b10) begin failures++; $display("FAIL brd_grant got=%b want=10", {b_gnt, mem_we}); end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    checks++; if ({a_rvalid, b_rvalid} !== 2'b01) begin failures++; $display("FAIL brd_rvalid got=%b want=01", {a_rvalid, b_rvalid}); end
    checks++; if (b_rdata !== 8'h5A) begin failures++; $display("FAIL brd_data got=%h want=5a", b_rdata); end
    tick();
    checks++; if (b_rvalid !== 1'b0) begin failures++; $display("FAIL brd_rvalid_drop got=%b want=0", b_rvalid); end
  endtask

  task automatic test_a_read();
    drive(1, 8'h04, 0, 0, 0, 0);
    checks++; if ({a_gnt, b_gnt} !== 2'b10) begin failures++; $display("FAIL ard_grant got=%b want=10", {a_gnt, b_gnt}); end
    checks++; if (mem_addr !== 8'h04) begin failures++; $display("FAIL ard_addr got=%h want=04", mem_addr); end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    checks++; if ({a_rvalid, b_rvalid} !== 2'b10) begin failures++; $display("FAIL ard_rvalid got=%b want=10", {a_rvalid, b_rvalid}); end
    checks++; if (a_rdata !== 8'h33) begin failures++; $display("FAIL ard_data got=%h want=33", a_rdata); end
    tick();
  endtask

  task automatic test_starvation();
    logic want_a;
    for (int c = 0; c < 10; c++) begin
      drive(1, 8'h08, 1, 0, 8'h09, 0);
      want_a = (c == 4) || (c == 9);
      checks++; if ({a_gnt, b_gnt} !== {want_a, !want_a}) begin failures++; $display("FAIL starve_c%0d got=%b want=%b", c, {a_gnt, b_gnt}, {want_a, !want_a}); end
      checks++; if ({a_rvalid, b_rvalid} !== {exp_av, exp_bv}) begin failures++; $display("FAIL starve_rvalid_c%0d got=%b want=%b", c, {a_rvalid, b_rvalid}, {exp_av, exp_bv}); end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_write_then_read();
    drive(0, 0, 1, 1, 8'h20, 8'hC3);
    checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL wtr_we got=%b want=1", mem_we); end
    tick();
    drive(1, 8'h20, 0, 0, 0, 0);
    checks++; if (a_gnt !== 1'b1) begin failures++; $display("FAIL wtr_agnt got=%b want=1", a_gnt); end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (a_rvalid !== 1'b1 || a_rdata !== 8'hC3) begin failures++; $display("FAIL wtr_data got=%b/%h want=1/c3", a_rvalid, a_rdata); end
    tick();
  endtask

  task automatic test_reset_mid_read();
    // A reads back to back; reset lands while the second read is in flight.
    drive(1, 8'h04, 0, 0, 0, 0);
    tick();
    drive(1, 8'h05, 0, 0, 0, 0);
    checks++; if (a_rvalid !== 1'b1 || a_gnt !== 1'b1) begin failures++; $display("FAIL rmr_pre got=%b%b want=11", a_rvalid, a_gnt); end
    rst_n = 1'b0; a_req = 1'b0;
    ref_reset();
    #1;
    checks++; if (a_rvalid !== 1'b0) begin failures++; $display("FAIL rmr_async_clear got=%b want=0", a_rvalid); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (a_rvalid !== 1'b0) begin failures++; $display("FAIL rmr_after got=%b want=0", a_rvalid); end
    tick();
    checks++; if (a_rvalid !== 1'b0) begin failures++; $display("FAIL rmr_after2 got=%b want=0", a_rvalid); end
    // Starve A to the limit, then reset: priority must fall back to B.
    for (int c = 0; c < LIM; c++) begin
      drive(1, 8'h01, 1, 0, 8'h02, 0);
      tick();
    end
    drive(1, 8'h01, 1, 0, 8'h02, 0);
    checks++; if ({a_gnt, b_gnt} !== 2'b10) begin failures++; $display("FAIL rmr_prio got=%b want=10", {a_gnt, b_gnt}); end
    rst_n = 1'b0;
    ref_reset();
    #1;
    ref_eval();
    checks++; if ({a_gnt, b_gnt} !== 2'b01) begin failures++; $display("FAIL rmr_cnt_clear got=%b want=01", {a_gnt, b_gnt}); end
    checks++; if (b_rvalid !== 1'b0) begin failures++; $display("FAIL rmr_b_clear got=%b want=0", b_rvalid); end
    a_req = 1'b0; b_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1, 8'h01, 1, 0, 8'h02, 0);
    checks++; if ({a_gnt, b_gnt} !== 2'b01) begin failures++; $display("FAIL rmr_post got=%b want=01", {a_gnt, b_gnt}); end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_random();
    logic          pa = 1'b0, pb = 1'b0, pw = 1'b0;
    logic [AW-1:0] paa = '0, pba = '0;
    logic [DW-1:0] pbd = '0;
    for (int c = 0; c < 400; c++) begin
      if (!pa) begin pa = ($urandom_range(0, 3) != 0); paa = AW'(8'h40 + $urandom_range(0, 7)); end
      if (!pb) begin
        pb  = ($urandom_range(0, 3) != 0);
        pw  = $urandom_range(0, 1) == 1;
        pba = AW'(8'h40 + $urandom_range(0, 7));
        pbd = DW'($urandom);
      end
      drive(pa, paa, pb, pw, pba, pbd);
      checks++; if ({a_gnt, b_gnt} !== {e_agnt, e_bgnt}) begin failures++; $display("FAIL rnd_gnt c%0d got=%b want=%b", c, {a_gnt, b_gnt}, {e_agnt, e_bgnt}); end
      checks++; if (mem_addr !== e_addr || mem_we !== e_we || mem_wdata !== pbd) begin failures++; $display("FAIL rnd_mem c%0d got=%h/%b/%h want=%h/%b/%h", c, mem_addr, mem_we, mem_wdata, e_addr, e_we, pbd); end
      checks++; if ({a_rvalid, b_rvalid} !== {exp_av, exp_bv}) begin failures++; $display("FAIL rnd_rvalid c%0d got=%b want=%b", c, {a_rvalid, b_rvalid}, {exp_av, exp_bv}); end
      if (exp_av) begin
        checks++; if (a_rdata !== exp_rd) begin failures++; $display("FAIL rnd_adata c%0d got=%h want=%h", c, a_rdata, exp_rd); end
      end
      if (exp_bv) begin
        checks++; if (b_rdata !== exp_rd) begin failures++; $display("FAIL rnd_bdata c%0d got=%h want=%h", c, b_rdata, exp_rd); end
      end
      if (e_agnt) pa = 1'b0;
      if (e_bgnt) pb = 1'b0;
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ref_mem[i]  = DW'($urandom);
      sram_mem[i] = ref_mem[i];
    end
    ref_mem[4]  = 8'h33;
    sram_mem[4] = 8'h33;
    #1;
    test_reset();
    test_b_write_read();
    test_a_read();
    test_starvation();
    test_write_then_read();
    test_reset_mid_read();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
